// File: rtl/reg_bank_dump_ctrl.sv
// Halt-time debug sequencer: walks the register bank through decode port A and
// streams every word to the debug UART, most significant byte first.
module reg_bank_dump_ctrl #(
   parameter int unsigned NB_DATA  = 32,
   parameter int unsigned NB_REG   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [NB_DATA-1:0] data_ra_i,
   input  logic               tx_ready_i,
   output logic               select_debug_o,
   output logic [NB_REG-1:0]  addr_reg_debug_o,
   output logic [7:0]         tx_data_o,
   output logic               tx_valid_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int unsigned NUM_BYTES = NB_DATA / 8;
   localparam int unsigned REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [REG_W-1:0]  LAST_REG  = REG_W'(NUM_REGS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      LATCH,
      SEND,
      DONE
   } state_t;

   state_t              state, state_next;
   logic [REG_W-1:0]    reg_idx, reg_idx_next;
   logic [BYTE_W-1:0]   byte_idx, byte_idx_next;
   logic [NB_DATA-1:0]  word_q, word_next;
   logic [7:0]          byte_sel;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= IDLE;
         reg_idx  <= '0;
         byte_idx <= '0;
         word_q   <= '0;
      end else begin
         state    <= state_next;
         reg_idx  <= reg_idx_next;
         byte_idx <= byte_idx_next;
         word_q   <= word_next;
      end
   end

   always_comb begin
      state_next    = state;
      reg_idx_next  = reg_idx;
      byte_idx_next = byte_idx;
      word_next     = word_q;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_next   = SELECT;
               reg_idx_next = '0;
            end
         end
         SELECT: state_next = LATCH;
         LATCH: begin
            // address has been held for a full cycle, so data_ra_i is settled here
            word_next     = data_ra_i;
            byte_idx_next = '0;
            state_next    = SEND;
         end
         SEND: begin
            if (tx_ready_i) begin
               if (byte_idx != LAST_BYTE) begin
                  byte_idx_next = byte_idx + BYTE_W'(1);
               end else if (reg_idx != LAST_REG) begin
                  reg_idx_next = reg_idx + REG_W'(1);
                  state_next   = SELECT;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      byte_sel = '0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         if (byte_idx == BYTE_W'(i)) begin
            byte_sel = word_q[NB_DATA-1-8*i -: 8];
         end
      end
   end

   // Every output decodes from registered state, so an async reset clears them at once.
   always_comb begin
      select_debug_o = 1'b0;
      tx_valid_o     = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      case (state)
         SELECT, LATCH: begin
            select_debug_o = 1'b1;
            busy_o         = 1'b1;
         end
         SEND: begin
            select_debug_o = 1'b1;
            tx_valid_o     = 1'b1;
            busy_o         = 1'b1;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign addr_reg_debug_o = select_debug_o ? NB_REG'(reg_idx) : '0;
   assign tx_data_o        = tx_valid_o ? byte_sel : '0;

endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
// Bench for reg_bank_dump_ctrl: a register-bank model answers port A, and the
// byte stream is compared with one derived directly from the bank contents.
module tb_reg_bank_dump_ctrl;

   localparam int unsigned NB_DATA  = 32;
   localparam int unsigned NB_REG   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned NBY      = NB_DATA / 8;

   localparam int unsigned S_NB_DATA  = 16;
   localparam int unsigned S_NB_REG   = 2;
   localparam int unsigned S_NUM_REGS = 4;

   logic clk = 1'b0;
   logic rst;

   logic               start, ready, sel, valid, busy, done;
   logic [NB_DATA-1:0] data_ra;
   logic [NB_REG-1:0]  addr;
   logic [7:0]         tx_data;

   logic                 start_s, ready_s, sel_s, valid_s, busy_s, done_s;
   logic [S_NB_DATA-1:0] data_ra_s;
   logic [S_NB_REG-1:0]  addr_s;
   logic [7:0]           tx_data_s;

   logic [NB_DATA-1:0]   bank   [NUM_REGS];
   logic [S_NB_DATA-1:0] bank_s [S_NUM_REGS];
   logic [NB_DATA-1:0]   pipe_word = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int n_done, stable_err, addr_err, sel_err, busy_err, cyc_done;
   bit timed_out;

   always #5 clk = ~clk;

   // port A shows pipeline traffic unless the debug select is taken
   always @(posedge clk) pipe_word <= $urandom();
   assign data_ra   = sel   ? bank[addr]     : pipe_word;
   assign data_ra_s = sel_s ? bank_s[addr_s] : pipe_word[S_NB_DATA-1:0];

   reg_bank_dump_ctrl dut (
      .clock_i          (clk),
      .reset_i          (rst),
      .start_i          (start),
      .data_ra_i        (data_ra),
      .tx_ready_i       (ready),
      .select_debug_o   (sel),
      .addr_reg_debug_o (addr),
      .tx_data_o        (tx_data),
      .tx_valid_o       (valid),
      .busy_o           (busy),
      .done_o           (done)
   );

   reg_bank_dump_ctrl #(
      .NB_DATA  (S_NB_DATA),
      .NB_REG   (S_NB_REG),
      .NUM_REGS (S_NUM_REGS)
   ) dut_s (
      .clock_i          (clk),
      .reset_i          (rst),
      .start_i          (start_s),
      .data_ra_i        (data_ra_s),
      .tx_ready_i       (ready_s),
      .select_debug_o   (sel_s),
      .addr_reg_debug_o (addr_s),
      .tx_data_o        (tx_data_s),
      .tx_valid_o       (valid_s),
      .busy_o           (busy_s),
      .done_o           (done_s)
   );

   task automatic build_expected();
      exp_q.delete();
      for (int k = 0; k < int'(NUM_REGS); k++)
         for (int b = int'(NBY) - 1; b >= 0; b--)
            exp_q.push_back(8'((bank[k] >> (8 * b)) & 32'hFF));
   endtask

   task automatic fill_pattern();
      for (int k = 0; k < int'(NUM_REGS); k++) bank[k] = 32'hA500_0000 + 32'(k);
   endtask

   // Runs one dump from the IDLE cycle in which start is raised; returns in the
   // IDLE cycle after done (posedge+1). Only collects, never judges.
   task automatic run_dump(input bit bp, input bit extra_starts, input bit hold_start,
                           input int max_cycles);
      bit in_dump, held, saw_done, finished;
      logic [7:0] held_data;
      int cyc, lowrun;
      got.delete();
      n_done = 0; stable_err = 0; addr_err = 0; sel_err = 0; busy_err = 0;
      cyc_done = -1; timed_out = 0;
      in_dump = 0; held = 0; saw_done = 0; finished = 0; held_data = '0;
      cyc = 0; lowrun = 0;
      start = 1'b1;
      ready = 1'b1;
      while (!finished) begin
         @(negedge clk);
         if (in_dump) begin
            if (!busy) busy_err++;
            if (done) begin
               n_done++;
               cyc_done = cyc;
               saw_done = 1;
               if (sel) sel_err++;
            end else begin
               if (!sel) sel_err++;
               if (int'(addr) != got.size() / int'(NBY)) addr_err++;
            end
            if (valid && held && tx_data !== held_data) stable_err++;
            if (valid && ready) begin
               got.push_back(tx_data);
               held = 0;
            end else if (valid) begin
               held = 1;
               held_data = tx_data;
            end else begin
               held = 0;
            end
         end else if (sel || busy) begin
            sel_err++;
         end
         @(posedge clk);
         cyc++;
         in_dump = 1;
         #1;
         if (saw_done || cyc >= max_cycles) begin
            timed_out = !saw_done;
            finished = 1;
            start = hold_start;
            ready = 1'b1;
         end else begin
            start = hold_start ? 1'b1 : (extra_starts && ($urandom_range(0, 3) == 0));
            if (!bp) begin
               ready = 1'b1;
            end else if (lowrun > 0) begin
               ready = 1'b0;
               lowrun--;
            end else if ($urandom_range(0, 19) == 0) begin
               ready = 1'b0;
               lowrun = 9;
            end else begin
               ready = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   task automatic test_reset();
      int guard;
      rst = 1'b1; start = 1'b0; ready = 1'b1; start_s = 1'b0; ready_s = 1'b1;
      #1;
      vectors++;
      if ({sel, addr, tx_data, valid, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%h want=0", {sel, addr, tx_data, valid, busy, done});
      end
      vectors++;
      if ({sel_s, addr_s, tx_data_s, valid_s, busy_s, done_s} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs_small got=%h want=0",
                  {sel_s, addr_s, tx_data_s, valid_s, busy_s, done_s});
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      fill_pattern();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (!valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      vectors++;
      if (valid !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_reach_send got valid=%b want 1", valid);
      end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({sel, addr, tx_data, valid, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_send got=%h want=0", {sel, addr, tx_data, valid, busy, done});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({sel, valid, busy, done} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_idle_after got sel/valid/busy/done=%b want 0000",
                  {sel, valid, busy, done});
      end
      @(posedge clk); #1;
   endtask

   task automatic check_stream(input string name);
      vectors++;
      if (timed_out) begin
         miscompares++;
         $display("FAIL %s_timeout got no done want done", name);
      end
      vectors++;
      if (got.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s_count got=%0d want=%0d", name, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [7:0] g;
         g = (i < got.size()) ? got[i] : 8'hxx;
         vectors++;
         if (g !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_byte[%0d] got=%h want=%h", name, i, g, exp_q[i]);
         end
      end
      vectors++;
      if (n_done != 1) begin
         miscompares++;
         $display("FAIL %s_done_count got=%0d want=1", name, n_done);
      end
      vectors++;
      if (sel_err != 0 || addr_err != 0 || busy_err != 0) begin
         miscompares++;
         $display("FAIL %s_addr_select got sel_err=%0d addr_err=%0d busy_err=%0d want 0",
                  name, sel_err, addr_err, busy_err);
      end
   endtask

   task automatic test_full_dump();
      fill_pattern();
      build_expected();
      run_dump(0, 0, 0, 1000);
      check_stream("full");
      // start cycle counted as cycle 1
      vectors++;
      if (cyc_done + 1 != 194) begin
         miscompares++;
         $display("FAIL full_done_cycle got=%0d want=194", cyc_done + 1);
      end
      @(negedge clk);
      vectors++;
      if ({busy, done, sel} !== 3'b000) begin
         miscompares++;
         $display("FAIL full_idle_after got busy/done/sel=%b want 000", {busy, done, sel});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      fill_pattern();
      build_expected();
      run_dump(1, 0, 0, 5000);
      check_stream("bp");
      vectors++;
      if (stable_err != 0) begin
         miscompares++;
         $display("FAIL bp_hold_stable got=%0d changes want=0", stable_err);
      end
   endtask

   task automatic test_random_content();
      for (int k = 0; k < int'(NUM_REGS); k++) bank[k] = $urandom();
      build_expected();
      run_dump(1, 0, 0, 5000);
      check_stream("rand");
      vectors++;
      if (stable_err != 0) begin
         miscompares++;
         $display("FAIL rand_hold_stable got=%0d changes want=0", stable_err);
      end
   endtask

   task automatic test_start_while_busy();
      fill_pattern();
      build_expected();
      run_dump(1, 1, 0, 5000);
      check_stream("busy_start");
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_start_no_restart got busy=%b want 0", busy);
      end
      @(posedge clk); #1;
      run_dump(0, 0, 1, 1000);
      vectors++;
      if (n_done != 1) begin
         miscompares++;
         $display("FAIL hold_done_count got=%0d want=1", n_done);
      end
      @(negedge clk);
      vectors++;
      if ({busy, sel} !== 2'b00) begin
         miscompares++;
         $display("FAIL hold_idle_cycle got busy/sel=%b want 00", {busy, sel});
      end
      @(negedge clk);
      vectors++;
      if ({busy, sel, addr} !== {2'b11, 5'd0}) begin
         miscompares++;
         $display("FAIL hold_retrigger got busy/sel/addr=%b want 1100000", {busy, sel, addr});
      end
      start = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_small_params();
      logic [7:0] sgot[$];
      logic [7:0] sexp[$];
      int sdone, scyc, cyc;
      for (int k = 0; k < int'(S_NUM_REGS); k++) bank_s[k] = 16'h1230 + 16'(k);
      for (int k = 0; k < int'(S_NUM_REGS); k++) begin
         sexp.push_back(8'(bank_s[k] >> 8));
         sexp.push_back(8'(bank_s[k] & 16'hFF));
      end
      sdone = 0; scyc = -1; cyc = 0;
      start_s = 1'b1; ready_s = 1'b1;
      while (sdone == 0 && cyc < 200) begin
         @(negedge clk);
         if (valid_s && ready_s) sgot.push_back(tx_data_s);
         if (done_s) begin
            sdone++;
            scyc = cyc;
         end
         @(posedge clk); #1;
         cyc++;
         start_s = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         if (done_s) sdone++;
      end
      vectors++;
      if (sgot.size() != sexp.size()) begin
         miscompares++;
         $display("FAIL small_count got=%0d want=%0d", sgot.size(), sexp.size());
      end
      for (int i = 0; i < sexp.size(); i++) begin
         logic [7:0] g;
         g = (i < sgot.size()) ? sgot[i] : 8'hxx;
         vectors++;
         if (g !== sexp[i]) begin
            miscompares++;
            $display("FAIL small_byte[%0d] got=%h want=%h", i, g, sexp[i]);
         end
      end
      vectors++;
      if (sdone != 1) begin
         miscompares++;
         $display("FAIL small_done_count got=%0d want=1", sdone);
      end
      vectors++;
      if (scyc + 1 != 1 + 4 * (2 + 2) + 1) begin
         miscompares++;
         $display("FAIL small_done_cycle got=%0d want=%0d", scyc + 1, 1 + 4 * (2 + 2) + 1);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_random_content();
      test_start_while_busy();
      test_small_params();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
